trainer_stim_sequencer: RTL and testbench

TRAINER_STIM_SEQUENCER -- requirements
Module: trainer_stim_sequencer

---
 rtl/trainer_stim_sequencer.sv | 175 +++++++++++++++++
 tb/tb_trainer_stim_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trainer_stim_sequencer.sv
// Walks sel through gates 0..6, drives each {a,b} combo, captures gate_y into a 4-bit truth table.
// Optional 2-flop step_btn synchronizer before the debouncer: define TRAINER_SEQ_BTN_SYNC_EN.
module trainer_stim_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 2,
    parameter int AUTO_PERIOD     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_btn,
    input  logic       auto_en,
    input  logic       gate_y,
    output logic       a,
    output logic       b,
    output logic [2:0] sel,
    output logic [3:0] tt_row,
    output logic [2:0] tt_sel,
    output logic       tt_valid,
    output logic       busy
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int STL_W = (SETTLE_CYCLES > 1)   ? $clog2(SETTLE_CYCLES)   : 1;
    localparam int AP_W  = (AUTO_PERIOD > 1)     ? $clog2(AUTO_PERIOD)     : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SETTLE, S_CAPTURE, S_ADVANCE
    } state_e;

    logic btn_in;

`ifdef TRAINER_SEQ_BTN_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], step_btn};
    end
    assign btn_in = sync_q[1];
`else
    assign btn_in = step_btn;
`endif

    // Level flips only after DEBOUNCE_CYCLES consecutive opposite samples.
    logic            db_q, db_prev_q;
    logic [DB_W-1:0] db_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            db_prev_q <= db_q;
            if (btn_in != db_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_q     <= btn_in;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    state_e          state_q, state_d;
    logic [AP_W-1:0] auto_cnt_q;
    logic            manual_step, auto_hit, step_evt;

    assign manual_step = db_q & ~db_prev_q & ~auto_en;
    assign auto_hit    = auto_en && (state_q == S_IDLE) &&
                         (auto_cnt_q == AP_W'(AUTO_PERIOD - 1));
    assign step_evt    = manual_step | auto_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          auto_cnt_q <= '0;
        else if (auto_en && state_q == S_IDLE && !auto_hit)  auto_cnt_q <= auto_cnt_q + AP_W'(1);
        else                                                 auto_cnt_q <= '0;
    end

    logic [1:0]       idx_q, idx_d;
    logic [STL_W-1:0] stl_cnt_q, stl_cnt_d;
    logic [2:0]       sel_q, sel_d, tt_sel_q, tt_sel_d;
    logic [3:0]       tt_row_q, tt_row_d;
    logic             tt_valid_q, tt_valid_d, busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            stl_cnt_q  <= '0;
            sel_q      <= '0;
            tt_sel_q   <= '0;
            tt_row_q   <= '0;
            tt_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            stl_cnt_q  <= stl_cnt_d;
            sel_q      <= sel_d;
            tt_sel_q   <= tt_sel_d;
            tt_row_q   <= tt_row_d;
            tt_valid_q <= tt_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Step events outside IDLE fall through unused, so they are dropped rather than queued.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stl_cnt_d  = stl_cnt_q;
        sel_d      = sel_q;
        tt_sel_d   = tt_sel_q;
        tt_row_d   = tt_row_q;
        tt_valid_d = tt_valid_q;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (step_evt) begin
                    state_d    = S_DRIVE;
                    tt_valid_d = 1'b0;
                    busy_d     = 1'b1;
                    idx_d      = 2'd0;
                end
            end
            S_DRIVE: begin
                stl_cnt_d = '0;
                state_d   = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
            end
            S_SETTLE: begin
                if (stl_cnt_q == STL_W'(SETTLE_CYCLES - 1)) state_d = S_CAPTURE;
                else                                        stl_cnt_d = stl_cnt_q + STL_W'(1);
            end
            S_CAPTURE: begin
                tt_row_d[idx_q] = gate_y;
                if (idx_q == 2'd3) begin
                    state_d = S_ADVANCE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_DRIVE;
                end
            end
            S_ADVANCE: begin
                tt_sel_d   = sel_q;
                tt_valid_d = 1'b1;
                sel_d      = (sel_q == 3'd6) ? 3'd0 : sel_q + 3'd1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [1:0] ab;
    always_comb begin
        ab = 2'b00;
        if (state_q == S_DRIVE || state_q == S_SETTLE || state_q == S_CAPTURE)
            ab = idx_q;
    end

    assign a        = ab[1];
    assign b        = ab[0];
    assign sel      = sel_q;
    assign tt_row   = tt_row_q;
    assign tt_sel   = tt_sel_q;
    assign tt_valid = tt_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_trainer_stim_sequencer.sv
// Directed bench for trainer_stim_sequencer with a behavioural gate-select model on gate_y.
module tb_trainer_stim_sequencer;

    localparam int DB = 4;
    localparam int ST = 2;
    localparam int AP = 50;

    logic       clk, rst_n, step_btn, auto_en, gate_y, a, b;
    logic [2:0] sel, tt_sel;
    logic [3:0] tt_row;
    logic       tt_valid, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int starts   = 0;
    int busy_cyc = 0;
    int vrises   = 0;
    int start_at [0:63];
    logic busy_prev  = 1'b0;
    logic valid_prev = 1'b0;

    trainer_stim_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .SETTLE_CYCLES  (ST),
        .AUTO_PERIOD    (AP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_btn(step_btn),
        .auto_en (auto_en),
        .gate_y  (gate_y),
        .a       (a),
        .b       (b),
        .sel     (sel),
        .tt_row  (tt_row),
        .tt_sel  (tt_sel),
        .tt_valid(tt_valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        gate_y = 1'b0;
        case (sel)
            3'd0: gate_y = a & b;
            3'd1: gate_y = a | b;
            3'd2: gate_y = a ^ b;
            3'd3: gate_y = ~(a & b);
            3'd4: gate_y = ~(a | b);
            3'd5: gate_y = a & ~b;
            3'd6: gate_y = ~(a ^ b);
            default: gate_y = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n === 1'b1) begin
            if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
            if (busy === 1'b1 && busy_prev !== 1'b1) begin
                if (starts < 64) start_at[starts] <= cyc;
                starts <= starts + 1;
            end
            if (tt_valid === 1'b1 && valid_prev !== 1'b1) vrises <= vrises + 1;
        end
        busy_prev  <= busy;
        valid_prev <= tt_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_busy(input logic val, input int bound, input string tag);
        int n;
        n = 0;
        while (busy !== val && n < bound) begin
            tick(1);
            n++;
        end
        chk(tag, busy, val);
    endtask

    task automatic press();
        step_btn = 1'b1;
        wait_busy(1'b1, 20, "press_start");
        wait_busy(1'b0, 40, "press_end");
        step_btn = 1'b0;
        tick(8);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ab"},       {a, b},   2'b00);
        chk({tag, "_sel"},      sel,      3'd0);
        chk({tag, "_tt_row"},   tt_row,   4'd0);
        chk({tag, "_tt_sel"},   tt_sel,   3'd0);
        chk({tag, "_tt_valid"}, tt_valid, 1'b0);
        chk({tag, "_busy"},     busy,     1'b0);
    endtask

    initial begin
        int s0, s1, v0, bc0, n;
        rst_n    = 1'b1;
        step_btn = 1'b0;
        auto_en  = 1'b0;

        // Reset with random inputs: outputs go to 0 without waiting for a clock edge.
        #2;
        rst_n    = 1'b0;
        step_btn = 1'($urandom_range(0, 1));
        auto_en  = 1'($urandom_range(0, 1));
        #1;
        chk_reset_outs("rst_async");
        for (int i = 0; i < 4; i++) begin
            step_btn = 1'($urandom_range(0, 1));
            auto_en  = 1'($urandom_range(0, 1));
            tick(1);
        end
        chk_reset_outs("rst_hold");
        step_btn = 1'b0;
        auto_en  = 1'b0;
        tick(1);
        rst_n = 1'b1;
        s0 = starts;
        tick(20);
        chk("rst_quiet_starts", starts - s0, 0);
        chk("rst_quiet_busy", busy, 1'b0);

        // Bouncing button, then held high: exactly one sequence, combos 0..3 in order.
        s0  = starts;
        bc0 = busy_cyc;
        for (int k = 0; k < 10; k++) begin
            step_btn = (k % 2 == 0);
            tick(2);
        end
        step_btn = 1'b1;
        wait_busy(1'b1, 20, "bounce_start");
        chk("drive_combo0", {a, b}, 2'd0);
        tick(4);
        chk("drive_combo1", {a, b}, 2'd1);
        tick(4);
        chk("drive_combo2", {a, b}, 2'd2);
        tick(4);
        chk("drive_combo3", {a, b}, 2'd3);
        tick(4);
        chk("advance_busy", busy, 1'b1);
        tick(1);
        chk("bounce_end_busy", busy, 1'b0);
        chk("idle_ab", {a, b}, 2'd0);
        chk("bounce_starts", starts - s0, 1);
        chk("bounce_busy_len", busy_cyc - bc0, 17);
        chk("bounce_tt_row", tt_row, 4'b1000);
        chk("bounce_tt_sel", tt_sel, 3'd0);
        chk("bounce_tt_valid", tt_valid, 1'b1);
        chk("bounce_sel", sel, 3'd1);
        step_btn = 1'b0;
        tick(8);

        // Second press 5 cycles into a running sequence is dropped.
        s0 = starts;
        v0 = vrises;
        step_btn = 1'b1;
        wait_busy(1'b1, 20, "busy_press_start");
        step_btn = 1'b0;
        tick(5);
        step_btn = 1'b1;
        wait_busy(1'b0, 40, "busy_press_end");
        tick(10);
        chk("busy_press_starts", starts - s0, 1);
        chk("busy_press_vrises", vrises - v0, 1);
        chk("busy_press_sel", sel, 3'd2);
        chk("busy_press_tt_sel", tt_sel, 3'd1);
        chk("busy_press_tt_row", tt_row, 4'b1110);
        step_btn = 1'b0;
        tick(8);

        // Remaining presses walk tt_sel to 6 and wrap sel.
        for (int s = 2; s <= 6; s++) begin
            press();
            chk("wrap_tt_sel", tt_sel, s);
            chk("wrap_tt_valid", tt_valid, 1'b1);
            if (s == 6) chk("wrap_tt_row_xnor", tt_row, 4'b1001);
        end
        chk("wrap_sel", sel, 3'd0);

        // Auto mode: starts 67 cycles apart; dropping auto_en mid-sequence lets it finish.
        s0 = starts;
        auto_en = 1'b1;
        n = 0;
        while (starts < s0 + 3 && n < 400) begin
            tick(1);
            n++;
        end
        chk("auto_starts", starts - s0, 3);
        chk("auto_gap1", start_at[s0 + 1] - start_at[s0], AP + 17);
        chk("auto_gap2", start_at[s0 + 2] - start_at[s0 + 1], AP + 17);
        tick(5);
        auto_en = 1'b0;
        chk("auto_midseq_busy", busy, 1'b1);
        wait_busy(1'b0, 30, "auto_end");
        chk("auto_tt_sel", tt_sel, 3'd2);
        chk("auto_sel", sel, 3'd3);
        s1 = starts;
        tick(150);
        chk("auto_off_starts", starts - s1, 0);

        // Reset during SETTLE of combo 2, then a fresh sequence from sel=0.
        step_btn = 1'b1;
        wait_busy(1'b1, 20, "rstmid_start");
        step_btn = 1'b0;
        tick(9);
        chk("rstmid_settle_combo2", {a, b}, 2'd2);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rstmid");
        tick(2);
        rst_n = 1'b1;
        s1 = starts;
        tick(10);
        chk("rstmid_quiet", starts - s1, 0);
        press();
        chk("rstmid_tt_sel", tt_sel, 3'd0);
        chk("rstmid_sel", sel, 3'd1);
        chk("rstmid_tt_row", tt_row, 4'b1000);
        chk("rstmid_tt_valid", tt_valid, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
